keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and turns key presses into debounced hex key events for the Spartan-6 debug top level.
- It is the input-side counterpart to the multiplexed 7-segment display driver. The display driver scans digits out; this block scans rows out and reads columns back.
- Pressed hex digits are accumulated into a 16-bit value. The top level uses that value as an operand source, for example a switch-selected display or an address entry.

Parameters:
- SCAN_DIV, 25000: clock cycles each row is driven before its columns are sampled. Must be >= 4. 25000 gives 1 ms at 25 MHz.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix scans required before a snapshot is accepted. Range 2..15.
- REPEAT_SCANS, 128: auto-repeat interval, in full scans. Only used when KEYPAD_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock, the 25 MHz PLL output.
- rst  input  1  asynchronous reset, active-high.
- row_n  output  4  keypad row drive, one-hot active-low.
- col_n  input  4  keypad column sense, active-low, externally pulled up, asynchronous to clk.
- key_code  output  4  hex code of the last accepted press, computed as row*4+col.
- key_valid  output  1  one-cycle pulse per accepted press.
- key_down  output  1  level; high while exactly one key is accepted as held.
- digits  output  16  shift register of entered hex digits; the newest digit is in [3:0].

Behaviour:
- Column synchronisation:
  - col_n passes through a 2-flop synchroniser; both flops reset to 4'b1111.
  - All sampling uses the synchronised value.
- Row scan:
  - Row index r runs 0..3. row_n = ~(1<<r).
  - A dwell counter counts 0..SCAN_DIV-1.
  - On the cycle the counter equals SCAN_DIV-1, the synchronised, inverted columns are written into snap[4r+3:4r]. On the same cycle the counter clears and r increments, wrapping 3->0.
  - One full scan takes 4*SCAN_DIV cycles.
- Scan completion:
  - The sample of row 3 completes a scan.
  - On the next cycle, scan_done (a registered strobe) evaluates snap against prev_snap.
- Debounce:
  - If snap != prev_snap: stable_cnt <= 1.
  - Otherwise: stable_cnt <= min(stable_cnt+1, DEBOUNCE_SCANS).
  - prev_snap <= snap on every scan_done.
  - When stable_cnt reaches DEBOUNCE_SCANS, snap is accepted: acc <= snap.
- Classification of acc: NONE (0 bits set), SINGLE (1 bit set, index k), MULTI (2 or more bits set).
- Events, evaluated one cycle after acc updates:
  - NONE -> SINGLE k: key_valid=1 for one cycle; key_code <= k; digits <= {digits[11:0], k}; key_down <= 1.
  - SINGLE k -> SINGLE j (j != k) without passing through NONE: treated as MULTI. No pulse; key_down <= 0.
  - Any -> MULTI: no pulse; key_down <= 0. A press is not reported again until acc returns to NONE.
  - Any -> NONE: key_down <= 0, no pulse; the MULTI lockout is cleared.
  - key_code and digits hold their values between events.
- Latency: a bounce-free press held from the start of a scan raises key_valid within (DEBOUNCE_SCANS+1) scans + 3 cycles.
- Reset (asynchronous, any time):
  - row_n=4'b1110; counters=0, r=0.
  - snap, prev_snap, acc = 0; stable_cnt=0.
  - key_code=0, key_valid=0, key_down=0, digits=16'h0000; lockout cleared.
  - A key held through reset release produces one fresh press event after debounce.
- Wrap-around: digits discards its top nibble on each shift. key_valid never stays high for more than one cycle.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - While acc stays SINGLE k, a repeat counter counts scan_done strobes.
  - The first repeat fires after 2*REPEAT_SCANS scans, then one every REPEAT_SCANS scans.
  - Each repeat pulses key_valid and shifts k into digits.
  - The counter clears on any change of acc and on reset.
- Undefined: no repeat logic and no repeat counter. Exactly one event per press.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=4; one scan = 16 cycles):
1. Reset, no keys pressed -> row_n=1110 then rotates 1101, 1011, 0111 every 4 cycles; key_valid never asserts; digits=0000.
2. Key 6 held (col_n[2]=0 whenever row_n[1]=0) -> exactly one key_valid pulse; key_code=6, key_down=1, digits=0006. On release -> key_down=0 after debounce, no pulse.
3. Key 9 bounces for 2 scans then holds stable -> exactly one pulse, key_code=9; no pulse is emitted during the bounce.
4. Press and release 1, 2, 3, A in turn -> four pulses; digits=123A. Then press 5 -> digits=23A5.
5. Keys 0 and 5 together -> no pulse, key_down=0. Release 5 with 0 still held -> no pulse. Release all, then press 0 -> one pulse, key_code=0.
6. Key F held, rst asserted for 3 cycles mid-hold -> all outputs clear immediately. After rst drops with F still held -> one new pulse, key_code=F, digits=000F. With KEYPAD_REPEAT_EN defined, holding F for 16 more scans -> further pulses at scan offsets 8, 12 and 16 after acceptance.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Bundles the keypad matrix pins and the decoded key outputs of
//   keypad_scanner.
//   master : the scanner (drives rows and key outputs, reads columns)
//   slave  : the keypad / top level (drives columns, reads everything else)
//   Signals:
//     row_n     [3:0]  row drive, one-hot active-low
//     col_n     [3:0]  column sense, active-low, asynchronous
//     key_code  [3:0]  hex code of last accepted press
//     key_valid        one-cycle pulse per accepted press
//     key_down         high while exactly one key is held
//     digits   [15:0]  entered hex digits, newest in [3:0]
interface keypad_scanner_if;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] digits;

    modport master (
        output row_n, key_code, key_valid, key_down, digits,
        input  col_n
    );

    modport slave (
        input  row_n, key_code, key_valid, key_down, digits,
        output col_n
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad row by row, debounces whole-matrix
//   snapshots and turns single-key presses into hex key events that are
//   also accumulated into a 16-bit digit shift register.
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active-high
//     bus   keypad_scanner_if.master (row_n, col_n, key_code, key_valid,
//           key_down, digits)
//   Parameters:
//     SCAN_DIV        cycles each row is driven before sampling (>= 4)
//     DEBOUNCE_SCANS  identical full scans needed to accept (2..15)
//     REPEAT_SCANS    auto-repeat interval in scans
//   Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of a held key).
module keypad_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 128
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_MAX  = 4'(DEBOUNCE_SCANS);

    // column synchroniser
    logic [3:0]       r_col_s1, r_col_s2;

    // row scan
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [15:0]      r_snap;
    logic             r_scan_done;

    // debounce
    logic [15:0]      r_prev_snap;
    logic [15:0]      r_acc;
    logic [3:0]       r_stable_cnt;
    logic             r_evt;          // acc was written last cycle

    // events
    logic [15:0]      r_acc_prev;     // acc seen at the previous event
    logic             r_lock;         // multi-key lockout
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_down;
    logic [15:0]      r_digits;

    logic             w_sample;
    logic [3:0]       w_cnt_next;
    logic [4:0]       w_nbits;
    logic [3:0]       w_idx;
    logic             w_none;
    logic             w_single;

    assign w_sample = (r_div == DIV_LAST);

    // Saturating stable count as it will be after this scan_done.
    always_comb begin
        w_cnt_next = r_stable_cnt;
        if (r_snap != r_prev_snap)
            w_cnt_next = 4'd1;
        else if (r_stable_cnt < DEB_MAX)
            w_cnt_next = r_stable_cnt + 4'd1;
    end

    // Classify acc: bit count and index of the (highest) set bit.
    always_comb begin
        w_nbits = '0;
        w_idx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_acc[i]) begin
                w_nbits = w_nbits + 5'd1;
                w_idx   = 4'(i);
            end
        end
    end

    assign w_none   = (w_nbits == 5'd0);
    assign w_single = (w_nbits == 5'd1);

    // Scan front end: synchroniser, dwell counter, row rotation, snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_s1    <= 4'b1111;
            r_col_s2    <= 4'b1111;
            r_div       <= '0;
            r_row       <= '0;
            r_snap      <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_col_s1    <= bus.col_n;
            r_col_s2    <= r_col_s1;
            r_scan_done <= w_sample && (r_row == 2'd3);
            if (w_sample) begin
                r_snap[4*r_row +: 4] <= ~r_col_s2;
                r_div                <= '0;
                r_row                <= r_row + 2'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Debounce: accept the snapshot once it has been identical for
    // DEBOUNCE_SCANS consecutive scans; keeps re-accepting while stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_snap  <= '0;
            r_acc        <= '0;
            r_stable_cnt <= '0;
            r_evt        <= 1'b0;
        end else begin
            r_evt <= 1'b0;
            if (r_scan_done) begin
                r_prev_snap  <= r_snap;
                r_stable_cnt <= w_cnt_next;
                if (w_cnt_next == DEB_MAX) begin
                    r_acc <= r_snap;
                    r_evt <= 1'b1;
                end
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(2 * REPEAT_SCANS);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(2 * REPEAT_SCANS - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_SCANS);
    logic [RPT_W-1:0] r_rpt;
`endif

    // Event generation, one cycle after acc is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_prev  <= '0;
            r_lock      <= 1'b0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
            r_digits    <= '0;
`ifdef KEYPAD_REPEAT_EN
            r_rpt       <= '0;
`endif
        end else begin
            r_key_valid <= 1'b0;
            if (r_evt) begin
                r_acc_prev <= r_acc;
                if (w_none) begin
                    r_key_down <= 1'b0;
                    r_lock     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
                    r_rpt      <= '0;
`endif
                end else if (w_single && (r_acc_prev == 16'h0000) && !r_lock) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_idx;
                    r_digits    <= {r_digits[11:0], w_idx};
                    r_key_down  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                    r_rpt       <= '0;
`endif
                end else if (w_single && (r_acc == r_acc_prev)) begin
                    // same key still held: nothing changes
                end else begin
                    // a second key appeared, or the key changed without
                    // release: lock out until the matrix is empty again
                    r_key_down <= 1'b0;
                    r_lock     <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                    r_rpt      <= '0;
`endif
                end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (r_scan_done && r_key_down) begin
                // first repeat after 2*REPEAT_SCANS, then every REPEAT_SCANS
                if (r_rpt == RPT_FIRST) begin
                    r_rpt       <= RPT_RELOAD;
                    r_key_valid <= 1'b1;
                    r_digits    <= {r_digits[11:0], r_key_code};
                end else begin
                    r_rpt <= r_rpt + 1'b1;
                end
            end
`endif
        end
    end

    assign bus.row_n     = ~(4'b0001 << r_row);
    assign bus.key_code  = r_key_code;
    assign bus.key_valid = r_key_valid;
    assign bus.key_down  = r_key_down;
    assign bus.digits    = r_digits;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    logic [3:0]  sb[$];
    logic [15:0] exp_digits = '0;
    logic        prev_valid = 1'b0;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(3),
        .REPEAT_SCANS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif)
    );

    always #5 clk = ~clk;

    // keypad matrix model: a pressed key pulls its column low when its row is driven
    always_comb begin
        kif.col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!kif.row_n[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c]) kif.col_n[c] = 1'b0;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst) begin
            if (kif.key_valid) begin
                pulses++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse key_code=%h digits=%h", kif.key_code, kif.digits);
                end else begin
                    e = sb.pop_front();
                    exp_digits = {exp_digits[11:0], e};
                    if (kif.key_code !== e || kif.digits !== exp_digits) begin
                        fails++;
                        $display("FAIL pulse key_code=%h digits=%h expected key_code=%h digits=%h",
                                 kif.key_code, kif.digits, e, exp_digits);
                    end
                end
                if (prev_valid) begin
                    tests++;
                    fails++;
                    $display("FAIL valid_width key_valid high two cycles, expected one");
                end
            end
            prev_valid = kif.key_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        keys = '0;
        repeat (3) @(negedge clk);
        exp_digits = '0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] one;
            one = 4'b0001 << i;
            tests++;
            if (kif.row_n !== ~one) begin
                fails++;
                $display("FAIL reset_row_rotation step=%0d row_n=%b expected %b", i, kif.row_n, ~one);
            end
            repeat (SD) @(negedge clk);
        end
        wait_scans(4);
        tests++;
        if (pulses !== 0 || kif.digits !== 16'h0000 || kif.key_down !== 1'b0 || kif.key_code !== 4'h0) begin
            fails++;
            $display("FAIL reset_idle pulses=%0d digits=%h key_down=%b key_code=%h expected 0/0000/0/0",
                     pulses, kif.digits, kif.key_down, kif.key_code);
        end
    endtask

    task automatic test_single_key;
        int p0;
        p0 = pulses;
        keys = 16'h0040;
        sb.push_back(4'h6);
        wait_scans(7);
        tests++;
        if (pulses - p0 !== 1 || kif.key_code !== 4'h6 || kif.key_down !== 1'b1 || kif.digits !== 16'h0006) begin
            fails++;
            $display("FAIL key6_press pulses=%0d code=%h down=%b digits=%h expected 1/6/1/0006",
                     pulses - p0, kif.key_code, kif.key_down, kif.digits);
        end
        keys = '0;
        wait_scans(7);
        tests++;
        if (pulses - p0 !== 1 || kif.key_down !== 1'b0) begin
            fails++;
            $display("FAIL key6_release pulses=%0d down=%b expected 1/0", pulses - p0, kif.key_down);
        end
    endtask

    task automatic test_bounce;
        int p0;
        p0 = pulses;
        sb.push_back(4'h9);
        // chatter for two scans
        for (int i = 0; i < 2 * SCAN / 5; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (5) @(negedge clk);
        end
        tests++;
        if (pulses - p0 !== 0) begin
            fails++;
            $display("FAIL bounce_no_pulse pulses=%0d expected 0", pulses - p0);
        end
        keys = 16'h0200;
        wait_scans(7);
        tests++;
        if (pulses - p0 !== 1 || kif.key_code !== 4'h9) begin
            fails++;
            $display("FAIL bounce_press pulses=%0d code=%h expected 1/9", pulses - p0, kif.key_code);
        end
        keys = '0;
        wait_scans(7);
    endtask

    task automatic test_sequence;
        logic [3:0] seq [5];
        int p0;
        seq = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5};
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            keys = 16'h0001 << seq[i];
            sb.push_back(seq[i]);
            wait_scans(7);
            keys = '0;
            wait_scans(7);
            if (i == 3) begin
                tests++;
                if (kif.digits !== 16'h123A || pulses - p0 !== 4) begin
                    fails++;
                    $display("FAIL seq_123A digits=%h pulses=%0d expected 123A/4", kif.digits, pulses - p0);
                end
            end
        end
        tests++;
        if (kif.digits !== 16'h23A5) begin
            fails++;
            $display("FAIL seq_wrap digits=%h expected 23A5", kif.digits);
        end
    endtask

    task automatic test_multi_key;
        int p0;
        p0 = pulses;
        keys = 16'h0021;
        wait_scans(7);
        tests++;
        if (pulses - p0 !== 0 || kif.key_down !== 1'b0) begin
            fails++;
            $display("FAIL multi_press pulses=%0d down=%b expected 0/0", pulses - p0, kif.key_down);
        end
        keys = 16'h0001;
        wait_scans(7);
        tests++;
        if (pulses - p0 !== 0 || kif.key_down !== 1'b0) begin
            fails++;
            $display("FAIL multi_lockout pulses=%0d down=%b expected 0/0", pulses - p0, kif.key_down);
        end
        keys = '0;
        wait_scans(7);
        keys = 16'h0001;
        sb.push_back(4'h0);
        wait_scans(7);
        tests++;
        if (pulses - p0 !== 1 || kif.key_code !== 4'h0 || kif.key_down !== 1'b1) begin
            fails++;
            $display("FAIL multi_then_0 pulses=%0d code=%h down=%b expected 1/0/1",
                     pulses - p0, kif.key_code, kif.key_down);
        end
        keys = '0;
        wait_scans(7);
    endtask

    task automatic test_reset_mid_hold;
        int p0;
        keys = 16'h8000;
        sb.push_back(4'hF);
        wait_scans(7);
        tests++;
        if (kif.key_code !== 4'hF || kif.key_down !== 1'b1) begin
            fails++;
            $display("FAIL F_before_reset code=%h down=%b expected F/1", kif.key_code, kif.key_down);
        end
        sb.delete();
        rst = 1'b1;
        #1;
        tests++;
        if (kif.key_code !== 4'h0 || kif.key_down !== 1'b0 || kif.key_valid !== 1'b0 ||
            kif.digits !== 16'h0000 || kif.row_n !== 4'b1110) begin
            fails++;
            $display("FAIL async_reset code=%h down=%b valid=%b digits=%h row_n=%b expected 0/0/0/0000/1110",
                     kif.key_code, kif.key_down, kif.key_valid, kif.digits, kif.row_n);
        end
        repeat (3) @(negedge clk);
        exp_digits = '0;
        p0 = pulses;
        sb.push_back(4'hF);
        rst = 1'b0;
        wait_scans(7);
        tests++;
        if (pulses - p0 !== 1 || kif.key_code !== 4'hF || kif.digits !== 16'h000F || kif.key_down !== 1'b1) begin
            fails++;
            $display("FAIL F_after_reset pulses=%0d code=%h digits=%h down=%b expected 1/F/000F/1",
                     pulses - p0, kif.key_code, kif.digits, kif.key_down);
        end
`ifdef KEYPAD_REPEAT_EN
        p0 = pulses;
        repeat (3) sb.push_back(4'hF);
        wait_scans(16);
        tests++;
        if (pulses - p0 !== 3 || kif.digits !== 16'hFFFF) begin
            fails++;
            $display("FAIL repeat pulses=%0d digits=%h expected 3/FFFF", pulses - p0, kif.digits);
        end
`endif
        keys = '0;
        wait_scans(7);
    endtask

    initial begin
        test_reset;
        test_single_key;
        test_bounce;
        test_sequence;
        test_multi_key;
        test_reset_mid_hold;
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain outstanding=%0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
